// File: rtl/mul_pkg.sv
// Shared definitions for the 4x4 pipelined multiplier and its accumulator.
//   AW      : operand width of mul
//   PW      : product width of mul
//   MUL_LAT : cycles from operands at mul inputs to the matching product
//   state_e : accumulator FSM states
//   min_sw  : smallest sum width that can hold len products of pw bits
package mul_pkg;

  localparam int unsigned AW      = 4;
  localparam int unsigned PW      = 8;
  localparam int unsigned MUL_LAT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned min_sw(input int unsigned pw, input int unsigned len);
    return pw + $clog2(len);
  endfunction

endpackage

// File: rtl/mul.sv
// 4x4 unsigned multiplier, three register stages, no valid signal.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   a, b : operands
//   p    : product, valid MUL_LAT edges after a/b are sampled
module mul
  import mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [PW-1:0] p
);

  logic [AW-1:0] a_q, b_q;
  logic [PW-1:0] m_q, p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
      m_q <= PW'(a_q) * PW'(b_q);
      p_q <= m_q;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/valid_delay.sv
// 1-bit shift register used to align an operand-side valid with a pipelined result.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every stage
//   din  : valid in
//   dout : valid delayed by DEPTH cycles
module valid_delay #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vd_q <= '0;
    end else begin
      vd_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        vd_q[i] <= vd_q[i-1];
      end
    end
  end

  assign dout = vd_q[DEPTH-1];

endmodule

// File: rtl/mul_acc.sv
// Accumulates LEN consecutive valid products from mul into one sum.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   start     : begin or restart an accumulation run
//   op_valid  : high in the cycle operands are presented to mul
//   p         : product from mul
//   busy      : high while a run is in progress
//   sum       : result of the last completed run, held until the next one
//   sum_valid : one-cycle pulse when sum updates
//   err       : one-cycle pulse when a valid product arrives outside a run
module mul_acc
  import mul_pkg::*;
#(
  parameter int unsigned LEN     = 4,
  parameter int unsigned MUL_LAT = mul_pkg::MUL_LAT,
  parameter int unsigned PW      = mul_pkg::PW,
  parameter int unsigned SW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op_valid,
  input  logic [PW-1:0] p,
  output logic          busy,
  output logic [SW-1:0] sum,
  output logic          sum_valid,
  output logic          err
);

  localparam int unsigned CW = $clog2(LEN);

  state_e        state_q, state_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_valid;
  logic [SW-1:0] p_ext;
  logic [SW-1:0] acc_sum;

  // mul has no valid of its own; shift op_valid alongside it.
  valid_delay #(
    .DEPTH(MUL_LAT)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .din (op_valid),
    .dout(p_valid)
  );

  assign p_ext   = SW'(p);
  assign acc_sum = acc_q + p_ext;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (p_valid) begin
          err = 1'b1;
        end
      end
      ACC: begin
        // A product coinciding with a restart belongs to the abandoned run.
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (p_valid) begin
          if (cnt_q == CW'(LEN - 1)) begin
            sum_d   = acc_sum;
            state_d = DONE;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        err = p_valid;
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign busy      = (state_q == ACC);
  assign sum_valid = (state_q == DONE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_mul_acc.sv
// Directed bench for mul + mul_acc with a scoreboard of expected sums.
module tb_mul_acc;
  import mul_pkg::*;

  localparam int unsigned LEN = 4;
  localparam int unsigned SW  = 10;

  logic          clk = 1'b0;
  logic          rst, start, op_valid;
  logic [AW-1:0] a, b;
  logic [PW-1:0] p;
  logic          busy, sum_valid, err;
  logic [SW-1:0] sum;

  always #5 clk = ~clk;

  mul u_mul (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .p  (p)
  );

  mul_acc #(
    .LEN    (LEN),
    .MUL_LAT(MUL_LAT),
    .PW     (PW),
    .SW     (SW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_valid (op_valid),
    .p        (p),
    .busy     (busy),
    .sum      (sum),
    .sum_valid(sum_valid),
    .err      (err)
  );

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int sv_cnt = 0;
  int model_acc;
  logic [SW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (err) err_cnt++;
    if (sum_valid) sv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic begin_run();
    start = 1'b1;
    model_acc = 0;
    tick();
    start = 1'b0;
  endtask

  // Counted product: adds to the reference model.
  task automatic drive_op(input int aa, input int bb);
    op_valid = 1'b1;
    a = AW'(aa);
    b = AW'(bb);
    model_acc += aa * bb;
    tick();
    op_valid = 1'b0;
  endtask

  // Product expected to be dropped by the accumulator.
  task automatic drop_op(input int aa, input int bb);
    op_valid = 1'b1;
    a = AW'(aa);
    b = AW'(bb);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_sum(input string tag, input int exp_lat);
    int n;
    bit seen;
    logic [SW-1:0] exp;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sum_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (exp_lat >= 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check({tag, "_sum"}, 32'(sum), 32'(exp));
      end
      tick();
      check({tag, "_pulse"}, 32'(sum_valid), 32'd0);
    end
  endtask

  int e0, s0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op_valid = 1'b0;
    a = '0;
    b = '0;
    model_acc = 0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_sv", 32'(sum_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Products with no run open are dropped.
    e0 = err_cnt;
    s0 = sv_cnt;
    drop_op(1, 1);
    tick();
    drop_op(2, 2);
    repeat (6) tick();
    check("idle_err", 32'(err_cnt - e0), 32'd2);
    check("idle_sv", 32'(sv_cnt - s0), 32'd0);
    check("idle_sum", 32'(sum), 32'd0);

    // Back-to-back run.
    e0 = err_cnt;
    begin_run();
    check("run_busy", 32'(busy), 32'd1);
    drive_op(3, 5);
    drive_op(15, 15);
    drive_op(2, 7);
    drive_op(0, 9);
    exp_q.push_back(SW'(model_acc));
    wait_sum("basic", MUL_LAT);
    check("basic_abs", 32'(sum), 32'd254);
    check("basic_err", 32'(err_cnt - e0), 32'd0);

    // Gaps between products.
    begin_run();
    drive_op(3, 5);
    drive_op(15, 15);
    repeat (2) tick();
    drive_op(2, 7);
    repeat (5) tick();
    check("gap_busy", 32'(busy), 32'd1);
    drive_op(0, 9);
    exp_q.push_back(SW'(model_acc));
    wait_sum("gaps", MUL_LAT);

    // Largest possible sum.
    begin_run();
    for (int i = 0; i < 4; i++) drive_op(15, 15);
    exp_q.push_back(SW'(model_acc));
    wait_sum("max", MUL_LAT);
    check("max_abs", 32'(sum), 32'd900);

    // Extra product lands in DONE.
    e0 = err_cnt;
    begin_run();
    for (int i = 0; i < 4; i++) drive_op(3, 5);
    exp_q.push_back(SW'(model_acc));
    drop_op(15, 15);
    wait_sum("done_drop", -1);
    repeat (4) tick();
    check("done_err", 32'(err_cnt - e0), 32'd1);
    check("done_sum", 32'(sum), 32'd60);

    // Restart mid-run.
    begin_run();
    drive_op(15, 15);
    drive_op(15, 15);
    repeat (4) tick();
    check("rs_busy", 32'(busy), 32'd1);
    begin_run();
    for (int i = 0; i < 4; i++) drive_op(1, 1);
    exp_q.push_back(SW'(model_acc));
    wait_sum("restart", MUL_LAT);
    check("restart_abs", 32'(sum), 32'd4);

    // Reset mid-run, then a fresh run.
    begin_run();
    drive_op(3, 5);
    drive_op(3, 5);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_sum", 32'(sum), 32'd0);
    check("mrst_sv", 32'(sum_valid), 32'd0);
    begin_run();
    for (int i = 0; i < 4; i++) drive_op(3, 5);
    exp_q.push_back(SW'(model_acc));
    wait_sum("fresh", MUL_LAT);
    check("fresh_abs", 32'(sum), 32'd60);

    repeat (4) tick();
    check("total_err", 32'(err_cnt), 32'd3);
    check("total_sv", 32'(sv_cnt), 32'd6);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
